// File: rtl/multiplicador_pkg.sv
// ============================================================================
//  Module  : multiplicador_pkg
//  Brief   : Shared FSM encodings and 7-segment patterns for the multiplier
//            display path.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package multiplicador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Element k holds the pattern for decimal digit k.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

`default_nettype wire

// File: rtl/hex7seg.sv
// ============================================================================
//  Module  : hex7seg
//  Brief   : Combinational BCD digit to active-low 7-segment decoder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hex7seg
  import multiplicador_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Non-decimal codes cannot occur in valid BCD, so they simply show nothing.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) begin
      seg = SEG_DIGIT[digit];
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_conversor.sv
// ============================================================================
//  Module  : bcd_conversor
//  Brief   : Sequential double-dabble binary-to-BCD converter with
//            leading-zero-blanked 7-segment outputs.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_conversor
  import multiplicador_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int DIGITS        = 4,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [WIDTH-1:0]    BIN,
  input  logic                START,
  output logic                BUSY,
  output logic                DONE,
  output logic [4*DIGITS-1:0] BCD,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3
);

  localparam int CW   = $clog2(WIDTH);
  localparam int BW   = 4 * DIGITS;
  localparam int NHEX = (DIGITS > 4) ? DIGITS : 4;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_bin;
  logic [BW-1:0]     r_scratch;
  logic [BW-1:0]     w_adj;
  logic [DIGITS-1:0] w_blank;
  logic [6:0]        w_seg [NHEX];

  // Add-3 correction is applied to every digit before this cycle's shift.
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    assign w_adj[4*k +: 4] = (r_scratch[4*k +: 4] >= 4'd5) ?
                             (r_scratch[4*k +: 4] + 4'd3) :
                             r_scratch[4*k +: 4];
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bin     <= '0;
      r_scratch <= '0;
      BCD       <= '0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        IDLE: begin
          if (START) begin
            r_bin     <= BIN;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_scratch <= {w_adj[BW-2:0], r_bin[WIDTH-1]};
          r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          BCD     <= r_scratch;
          DONE    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BUSY = (r_state != IDLE);

  // A digit is blanked when it and every more significant digit are zero.
  for (genvar k = 0; k < DIGITS; k++) begin : g_blank
    if (k == 0) begin : g_lsd
      assign w_blank[k] = 1'b0;
    end else begin : g_upper
      assign w_blank[k] = BLANK_LEADING && (BCD[BW-1:4*k] == '0);
    end
  end

  for (genvar k = 0; k < NHEX; k++) begin : g_hex
    if (k < DIGITS) begin : g_dec
      hex7seg u_hex7seg (
        .digit (BCD[4*k +: 4]),
        .blank (w_blank[k]),
        .seg   (w_seg[k])
      );
    end else begin : g_pad
      assign w_seg[k] = SEG_BLANK;
    end
  end

  assign HEX0 = w_seg[0];
  assign HEX1 = w_seg[1];
  assign HEX2 = w_seg[2];
  assign HEX3 = w_seg[3];

endmodule

`default_nettype wire
